// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I(M) decode stage.
// Contents:
//   - opcode constants
//   - ALU operation codes (RV32I 0..10, RV32M 11..18)
//   - operand / writeback select encodings
//   - ctrl_t, the control bundle carried into EX
//   - sb_entry_t, one in-flight writer tracked by the scoreboard
//   - branch_cond(), which evaluates a branch from the EX comparator flags
package rv_ctrl_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [4:0] AluAdd    = 5'd0;
  localparam logic [4:0] AluSub    = 5'd1;
  localparam logic [4:0] AluSlt    = 5'd2;
  localparam logic [4:0] AluSltu   = 5'd3;
  localparam logic [4:0] AluXor    = 5'd4;
  localparam logic [4:0] AluOr     = 5'd5;
  localparam logic [4:0] AluAnd    = 5'd6;
  localparam logic [4:0] AluSll    = 5'd7;
  localparam logic [4:0] AluSrl    = 5'd8;
  localparam logic [4:0] AluSra    = 5'd9;
  localparam logic [4:0] AluLui    = 5'd10;  // pass operand B
  localparam logic [4:0] AluMul    = 5'd11;
  localparam logic [4:0] AluMulh   = 5'd12;
  localparam logic [4:0] AluMulhsu = 5'd13;
  localparam logic [4:0] AluMulhu  = 5'd14;
  localparam logic [4:0] AluDiv    = 5'd15;
  localparam logic [4:0] AluDivu   = 5'd16;
  localparam logic [4:0] AluRem    = 5'd17;
  localparam logic [4:0] AluRemu   = 5'd18;

  localparam logic       OpaRs1 = 1'b0;
  localparam logic       OpaPc  = 1'b1;
  localparam logic       OpbRs2 = 1'b0;
  localparam logic       OpbImm = 1'b1;
  localparam logic [1:0] WbPc4  = 2'b00;
  localparam logic [1:0] WbAlu  = 2'b01;
  localparam logic [1:0] WbMem  = 2'b10;

  typedef struct packed {
    logic       rd_wren;
    logic       mem_wren;
    logic       opa_sel;
    logic       opb_sel;
    logic [4:0] alu_op;
    logic [1:0] wb_sel;
    logic       br_un;     // 1 = signed compare, 0 = unsigned
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       is_branch;
    logic       is_jump;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       rd_wren;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic branch_cond(input logic [2:0] funct3, input logic less,
                                       input logic equal);
    logic cond;
    cond = 1'b0;
    case (funct3)
      3'b000:         cond = equal;    // BEQ
      3'b001:         cond = !equal;   // BNE
      3'b100, 3'b110: cond = less;     // BLT, BLTU
      3'b101, 3'b111: cond = !less;    // BGE, BGEU
      default:        cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I(M) instruction decoder.
// Ports:
//   i_instr     32-bit instruction word
//   o_ctrl      decoded control bundle (write enables cleared when illegal)
//   o_illegal   encoding not recognised
//   o_rs1_used  instruction reads rs1
//   o_rs2_used  instruction reads rs2
//   o_rs1/o_rs2 source register indices
module rv_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned EN_MEXT = 0
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.rd     = i_instr[11:7];
    o_ctrl.funct3 = w_funct3;
    o_illegal     = 1'b0;
    o_rs1_used    = 1'b0;
    o_rs2_used    = 1'b0;

    case (w_opcode)
      OpcOp: begin
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opa_sel = OpaRs1;
        o_ctrl.opb_sel = OpbRs2;
        o_ctrl.wb_sel  = WbAlu;
        o_rs1_used     = 1'b1;
        o_rs2_used     = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  o_ctrl.alu_op = AluAdd;
            3'b001:  o_ctrl.alu_op = AluSll;
            3'b010:  o_ctrl.alu_op = AluSlt;
            3'b011:  o_ctrl.alu_op = AluSltu;
            3'b100:  o_ctrl.alu_op = AluXor;
            3'b101:  o_ctrl.alu_op = AluSrl;
            3'b110:  o_ctrl.alu_op = AluOr;
            default: o_ctrl.alu_op = AluAnd;
          endcase
        end else if (w_funct7 == 7'b0100000) begin
          case (w_funct3)
            3'b000:  o_ctrl.alu_op = AluSub;
            3'b101:  o_ctrl.alu_op = AluSra;
            default: o_illegal     = 1'b1;
          endcase
        end else if ((w_funct7 == 7'b0000001) && (EN_MEXT != 0)) begin
          // MUL..REMU follow funct3 order
          o_ctrl.alu_op = AluMul + {2'b00, w_funct3};
        end else begin
          o_illegal = 1'b1;
        end
      end

      OpcOpImm: begin
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opa_sel = OpaRs1;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.wb_sel  = WbAlu;
        o_rs1_used     = 1'b1;
        case (w_funct3)
          3'b000: o_ctrl.alu_op = AluAdd;
          3'b010: o_ctrl.alu_op = AluSlt;
          3'b011: o_ctrl.alu_op = AluSltu;
          3'b100: o_ctrl.alu_op = AluXor;
          3'b110: o_ctrl.alu_op = AluOr;
          3'b111: o_ctrl.alu_op = AluAnd;
          3'b001: begin
            o_ctrl.alu_op = AluSll;
            if (w_funct7 != 7'b0000000) o_illegal = 1'b1;
          end
          default: begin
            if (w_funct7 == 7'b0000000)      o_ctrl.alu_op = AluSrl;
            else if (w_funct7 == 7'b0100000) o_ctrl.alu_op = AluSra;
            else                             o_illegal     = 1'b1;
          end
        endcase
      end

      OpcLoad: begin
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.alu_op  = AluAdd;
        o_ctrl.wb_sel  = WbMem;
        o_rs1_used     = 1'b1;
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: o_illegal = 1'b0;
          default:                                o_illegal = 1'b1;
        endcase
      end

      OpcStore: begin
        o_ctrl.mem_wren = 1'b1;
        o_ctrl.opb_sel  = OpbImm;
        o_ctrl.alu_op   = AluAdd;
        o_rs1_used      = 1'b1;
        o_rs2_used      = 1'b1;
        if (w_funct3 > 3'b010) o_illegal = 1'b1;
      end

      OpcBranch: begin
        // ALU forms the target PC + imm; the comparator works on rs1/rs2
        o_ctrl.is_branch = 1'b1;
        o_ctrl.opa_sel   = OpaPc;
        o_ctrl.opb_sel   = OpbImm;
        o_ctrl.alu_op    = AluAdd;
        o_ctrl.br_un     = (w_funct3[2:1] != 2'b11);
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) o_illegal = 1'b1;
      end

      OpcJal: begin
        o_ctrl.is_jump = 1'b1;
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opa_sel = OpaPc;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.alu_op  = AluAdd;
        o_ctrl.wb_sel  = WbPc4;
      end

      OpcJalr: begin
        o_ctrl.is_jump = 1'b1;
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opa_sel = OpaRs1;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.alu_op  = AluAdd;
        o_ctrl.wb_sel  = WbPc4;
        o_rs1_used     = 1'b1;
        if (w_funct3 != 3'b000) o_illegal = 1'b1;
      end

      OpcLui: begin
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.alu_op  = AluLui;
        o_ctrl.wb_sel  = WbAlu;
      end

      OpcAuipc: begin
        o_ctrl.rd_wren = 1'b1;
        o_ctrl.opa_sel = OpaPc;
        o_ctrl.opb_sel = OpbImm;
        o_ctrl.alu_op  = AluAdd;
        o_ctrl.wb_sel  = WbAlu;
      end

      default: o_illegal = 1'b1;
    endcase

    // An illegal instruction must not write anything, redirect, or hold up ID
    if (o_illegal) begin
      o_ctrl.rd_wren   = 1'b0;
      o_ctrl.mem_wren  = 1'b0;
      o_ctrl.is_branch = 1'b0;
      o_ctrl.is_jump   = 1'b0;
      o_rs1_used       = 1'b0;
      o_rs2_used       = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID stage control: decoder, ID/EX control register, RAW-hazard scoreboard,
// branch/jump redirect and a saturating stall counter.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_instr, i_id_valid   instruction in ID and its valid flag
//   i_br_less/equal       EX comparator results for the ID/EX instruction
//   o_id_stall            hold PC and IF/ID
//   o_ex_valid/ctrl       ID/EX contents
//   o_ex_illegal          ID/EX holds an illegal encoding
//   o_pc_sel, o_flush     redirect PC to EX target and squash IF/ID
//   o_stall_cnt           saturating count of stall cycles
module decode_ctrl_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 3,
  parameter int unsigned EN_MEXT  = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic             i_id_valid,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_id_stall,
  output logic             o_ex_valid,
  output ctrl_t            o_ex_ctrl,
  output logic             o_ex_illegal,
  output logic             o_pc_sel,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  ctrl_t      w_dec_ctrl;
  logic       w_dec_illegal;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  rv_decoder #(
    .EN_MEXT (EN_MEXT)
  ) u_decoder (
    .i_instr    (i_instr),
    .o_ctrl     (w_dec_ctrl),
    .o_illegal  (w_dec_illegal),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2)
  );

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic             r_ex_illegal;
  sb_entry_t        r_sb [SB_DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_hazard;
  logic             w_redirect;
  logic             w_bubble;
  logic             w_ex_valid_d;
  ctrl_t            w_ex_ctrl_d;
  logic             w_ex_illegal_d;

  // RAW hazard against every in-flight writer; x0 is never a real dependency
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < int'(SB_DEPTH); k++) begin
      if (r_sb[k].valid && r_sb[k].rd_wren && (r_sb[k].rd != 5'd0) &&
          ((w_rs1_used && (r_sb[k].rd == w_rs1)) ||
           (w_rs2_used && (r_sb[k].rd == w_rs2)))) begin
        w_hazard = 1'b1;
      end
    end
    w_hazard = w_hazard & i_id_valid;
  end

  assign w_redirect = r_ex_valid &
                      (r_ex_ctrl.is_jump |
                       (r_ex_ctrl.is_branch &
                        branch_cond(r_ex_ctrl.funct3, i_br_less, i_br_equal)));

  // Flush wins over stall: the stalled instruction is on the wrong path anyway
  assign w_bubble = w_redirect | w_hazard | ~i_id_valid;

  always_comb begin
    w_ex_valid_d   = 1'b1;
    w_ex_ctrl_d    = w_dec_ctrl;
    w_ex_illegal_d = w_dec_illegal;
    if (w_bubble) begin
      w_ex_valid_d   = 1'b0;
      w_ex_ctrl_d    = '0;
      w_ex_illegal_d = 1'b0;
    end
  end

  // Entry 0 is loaded alongside ID/EX so it always mirrors it; older
  // entries shift every cycle regardless of stalls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= '0;
      r_ex_illegal <= 1'b0;
      for (int k = 0; k < int'(SB_DEPTH); k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      r_ex_valid   <= w_ex_valid_d;
      r_ex_ctrl    <= w_ex_ctrl_d;
      r_ex_illegal <= w_ex_illegal_d;
      r_sb[0]      <= '{valid: w_ex_valid_d, rd_wren: w_ex_ctrl_d.rd_wren, rd: w_ex_ctrl_d.rd};
      for (int k = 1; k < int'(SB_DEPTH); k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if (o_id_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_id_stall   = w_hazard & ~w_redirect;
  assign o_ex_valid   = r_ex_valid;
  assign o_ex_ctrl    = r_ex_ctrl;
  assign o_ex_illegal = r_ex_illegal;
  assign o_pc_sel     = w_redirect;
  assign o_flush      = w_redirect;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe. Two instances share the stimulus:
// u_dut_a uses defaults (RV32M illegal, 16-bit counter), u_dut_b enables
// RV32M and uses a 2-bit counter to exercise saturation.
module tb_decode_ctrl_pipe;
  import rv_ctrl_pkg::*;

  localparam logic [31:0] InsAddX1    = 32'h003100B3;  // add  x1,x2,x3
  localparam logic [31:0] InsAddX4X1  = 32'h00508233;  // add  x4,x1,x5
  localparam logic [31:0] InsAddX6X4  = 32'h00420333;  // add  x6,x4,x4
  localparam logic [31:0] InsAddiX0   = 32'h00500013;  // addi x0,x0,5
  localparam logic [31:0] InsAddX2X0  = 32'h00000133;  // add  x2,x0,x0
  localparam logic [31:0] InsMul      = 32'h02208033;  // mul  x0,x1,x2
  localparam logic [31:0] InsSrai     = 32'h4030D093;  // srai x1,x1,3
  localparam logic [31:0] InsSlliBad  = 32'h40309093;  // slli, funct7=0100000
  localparam logic [31:0] InsBeq      = 32'h00000463;  // beq  x0,x0,+8
  localparam logic [31:0] InsBlt      = 32'h00004463;  // blt  x0,x0,+8
  localparam logic [31:0] InsJal      = 32'h008000EF;  // jal  x1,+8

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        id_valid;
  logic        br_less;
  logic        br_equal;

  logic        a_stall, a_ex_valid, a_illegal, a_pc_sel, a_flush;
  ctrl_t       a_ctrl;
  logic [15:0] a_cnt;
  logic        b_stall, b_ex_valid, b_illegal, b_pc_sel, b_flush;
  ctrl_t       b_ctrl;
  logic [1:0]  b_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  decode_ctrl_pipe u_dut_a (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_instr      (instr),
    .i_id_valid   (id_valid),
    .i_br_less    (br_less),
    .i_br_equal   (br_equal),
    .o_id_stall   (a_stall),
    .o_ex_valid   (a_ex_valid),
    .o_ex_ctrl    (a_ctrl),
    .o_ex_illegal (a_illegal),
    .o_pc_sel     (a_pc_sel),
    .o_flush      (a_flush),
    .o_stall_cnt  (a_cnt)
  );

  decode_ctrl_pipe #(
    .SB_DEPTH (3),
    .EN_MEXT  (1),
    .CNT_W    (2)
  ) u_dut_b (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_instr      (instr),
    .i_id_valid   (id_valid),
    .i_br_less    (br_less),
    .i_br_equal   (br_equal),
    .o_id_stall   (b_stall),
    .o_ex_valid   (b_ex_valid),
    .o_ex_ctrl    (b_ctrl),
    .o_ex_illegal (b_illegal),
    .o_pc_sel     (b_pc_sel),
    .o_flush      (b_flush),
    .o_stall_cnt  (b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    instr    = '0;
    id_valid = 1'b0;
    br_less  = 1'b0;
    br_equal = 1'b0;
    #2;
    check("rst_ex_valid", 32'(a_ex_valid), 32'd0);
    check("rst_ex_ctrl",  32'(a_ctrl),     32'd0);
    check("rst_illegal",  32'(a_illegal),  32'd0);
    check("rst_pc_sel",   32'(a_pc_sel),   32'd0);
    check("rst_flush",    32'(a_flush),    32'd0);
    check("rst_stall",    32'(a_stall),    32'd0);
    check("rst_cnt",      32'(a_cnt),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // RAW: add x1 then add x4,x1 -> three stall cycles, three bubbles
    instr    = InsAddX1;
    id_valid = 1'b1;
    #1;
    check("raw_prod_nostall", 32'(a_stall), 32'd0);
    tick();
    check("raw_prod_valid",  32'(a_ex_valid),     32'd1);
    check("raw_prod_rd",     32'(a_ctrl.rd),      32'd1);
    check("raw_prod_wren",   32'(a_ctrl.rd_wren), 32'd1);
    check("raw_prod_aluop",  32'(a_ctrl.alu_op),  32'(AluAdd));
    check("raw_prod_wbsel",  32'(a_ctrl.wb_sel),  32'(WbAlu));
    instr = InsAddX4X1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("raw_stall", 32'(a_stall), 32'd1);
      tick();
      check("raw_bubble", 32'(a_ex_valid), 32'd0);
    end
    check("raw_release",  32'(a_stall), 32'd0);
    check("raw_cnt_a",    32'(a_cnt),   32'd3);
    check("raw_cnt_b",    32'(b_cnt),   32'd3);
    tick();
    check("raw_cons_valid", 32'(a_ex_valid), 32'd1);
    check("raw_cons_rd",    32'(a_ctrl.rd),  32'd4);

    // Second dependency: two more stall cycles, narrow counter saturates
    instr = InsAddX6X4;
    #1;
    check("sat_stall", 32'(a_stall), 32'd1);
    tick();
    tick();
    check("sat_still_stall", 32'(a_stall), 32'd1);
    check("sat_cnt_a",       32'(a_cnt),   32'd5);
    check("sat_cnt_b",       32'(b_cnt),   32'd3);

    // Asynchronous reset in the middle of the stall
    rst_n = 1'b0;
    #1;
    check("arst_stall_a",  32'(a_stall),    32'd0);
    check("arst_stall_b",  32'(b_stall),    32'd0);
    check("arst_cnt_a",    32'(a_cnt),      32'd0);
    check("arst_cnt_b",    32'(b_cnt),      32'd0);
    check("arst_ex_valid", 32'(a_ex_valid), 32'd0);
    check("arst_pc_sel",   32'(a_pc_sel),   32'd0);
    check("arst_flush",    32'(a_flush),    32'd0);
    id_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Writer of x0 followed by reader of x0 never stalls
    instr    = InsAddiX0;
    id_valid = 1'b1;
    tick();
    instr = InsAddX2X0;
    #1;
    check("x0_nostall", 32'(a_stall), 32'd0);
    tick();
    check("x0_cons_valid", 32'(a_ex_valid), 32'd1);
    check("x0_cons_rd",    32'(a_ctrl.rd),  32'd2);
    drain();

    // mul: illegal without RV32M, alu_op 11 with it
    instr    = InsMul;
    id_valid = 1'b1;
    tick();
    check("mul_a_illegal", 32'(a_illegal),       32'd1);
    check("mul_a_valid",   32'(a_ex_valid),      32'd1);
    check("mul_a_wren",    32'(a_ctrl.rd_wren),  32'd0);
    check("mul_a_mwren",   32'(a_ctrl.mem_wren), 32'd0);
    check("mul_b_illegal", 32'(b_illegal),       32'd0);
    check("mul_b_aluop",   32'(b_ctrl.alu_op),   32'd11);
    check("mul_b_wren",    32'(b_ctrl.rd_wren),  32'd1);
    drain();

    // srai decodes to SRA; slli with funct7=0100000 is illegal
    instr    = InsSrai;
    id_valid = 1'b1;
    tick();
    check("srai_aluop",   32'(a_ctrl.alu_op),  32'(AluSra));
    check("srai_illegal", 32'(a_illegal),      32'd0);
    check("srai_opb",     32'(a_ctrl.opb_sel), 32'(OpbImm));
    drain();
    instr    = InsSlliBad;
    id_valid = 1'b1;
    tick();
    check("slli_illegal", 32'(a_illegal),      32'd1);
    check("slli_wren",    32'(a_ctrl.rd_wren), 32'd0);
    drain();

    // Taken beq in EX with a hazarding instruction in ID: flush beats stall
    instr    = InsAddX1;
    id_valid = 1'b1;
    tick();
    instr = InsBeq;
    #1;
    check("beq_id_nostall", 32'(a_stall), 32'd0);
    tick();
    instr    = InsAddX4X1;
    br_equal = 1'b0;
    #1;
    check("beq_nt_stall",  32'(a_stall),  32'd1);
    check("beq_nt_pc_sel", 32'(a_pc_sel), 32'd0);
    br_equal = 1'b1;
    #1;
    check("beq_t_pc_sel", 32'(a_pc_sel), 32'd1);
    check("beq_t_flush",  32'(a_flush),  32'd1);
    check("beq_t_stall",  32'(a_stall),  32'd0);
    tick();
    check("beq_t_bubble", 32'(a_ex_valid), 32'd0);
    br_equal = 1'b0;
    drain();

    // blt: taken on less, signed compare
    instr    = InsBlt;
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    br_less  = 1'b1;
    #1;
    check("blt_taken",  32'(a_pc_sel),     32'd1);
    check("blt_signed", 32'(a_ctrl.br_un), 32'd1);
    br_less = 1'b0;
    #1;
    check("blt_not_taken", 32'(a_pc_sel), 32'd0);
    tick();

    // jal always redirects and writes PC+4
    instr    = InsJal;
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("jal_pc_sel", 32'(a_pc_sel),       32'd1);
    check("jal_jump",   32'(a_ctrl.is_jump), 32'd1);
    check("jal_wbsel",  32'(a_ctrl.wb_sel),  32'(WbPc4));
    check("jal_wren",   32'(a_ctrl.rd_wren), 32'd1);
    tick();
    check("jal_after_bubble", 32'(a_ex_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 3: number of in-flight stages after ID (EX, MEM, WB) checked for RAW hazards, range 1..4.
REQ-002 SHALL have parameter EN_MEXT, default 0: 1 = decode RV32M (opcode 0110011, funct7 0000001), 0 = treat RV32M encodings as illegal.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-004 i_clk  in  1  single clock, rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_instr  in  32  instruction in ID.
REQ-007 i_id_valid  in  1  i_instr is valid.
REQ-008 i_br_less, i_br_equal  in  1 each  EX-stage comparator results for the instruction held in ID/EX.
REQ-009 o_id_stall  out  1  hold PC and IF/ID this cycle.
REQ-010 o_ex_valid  out  1  ID/EX holds a real instruction.
REQ-011 o_ex_ctrl  out  ctrl_t  registered control bundle: rd_wren, mem_wren, opa_sel, opb_sel, alu_op[4:0], wb_sel[1:0], br_un, rd[4:0], funct3, is_branch, is_jump.
REQ-012 o_ex_illegal  out  1  ID/EX holds an illegal encoding.
REQ-013 o_pc_sel  out  1  redirect PC to EX target.
REQ-014 o_flush  out  1  squash IF/ID.
REQ-015 o_stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-016 Decode SHALL be combinational from i_instr and cover R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC with the established select encodings: opa 0=rs1/1=PC; opb 0=rs2/1=imm; wb 00=PC+4, 01=ALU, 10=MEM; br_un 1=signed, 0=unsigned.
REQ-017 SRAI/SRLI SHALL be selected by funct7 0100000/0000000; SLLI with funct7≠0, and any other funct7, funct3 or opcode not listed, SHALL be illegal.
REQ-018 With EN_MEXT=1, MUL..REMU SHALL map to alu_op 11..18.
REQ-019 rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 by R, STORE, BRANCH; LUI, AUIPC and JAL use neither.
REQ-020 Scoreboard SHALL be a SB_DEPTH-entry shift register of {valid, rd_wren, rd}; entry 0 mirrors ID/EX and the register shifts every cycle unconditionally.
REQ-021 hazard = i_id_valid & any entry k with valid & rd_wren & rd≠0 & rd equal to a used source register.
REQ-022 o_pc_sel = o_ex_valid & (is_jump | (is_branch & condition)); condition per funct3: BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less.
REQ-023 o_flush SHALL equal o_pc_sel.
REQ-024 o_id_stall = hazard & !o_flush; a flush has priority over a stall.
REQ-025 At each edge ID/EX SHALL load a bubble (valid=0, rd_wren=0, mem_wren=0, is_branch=0, is_jump=0) when o_flush, hazard or !i_id_valid; otherwise it SHALL load the decoded bundle.
REQ-026 An illegal instruction SHALL enter ID/EX with valid=1, o_ex_illegal=1 and every write enable 0.
REQ-027 Decode-to-EX latency SHALL be 1 cycle; a stall SHALL last until the producer leaves entry SB_DEPTH-1.
REQ-028 o_stall_cnt SHALL increment on each cycle with o_id_stall=1 and hold at 2^CNT_W-1.

Reset
REQ-029 While i_reset=0, ID/EX SHALL hold a bubble, all scoreboard entries SHALL be invalid, and o_stall_cnt, o_ex_illegal, o_pc_sel, o_flush and o_id_stall SHALL be 0.
REQ-030 Reset asserted mid-stall SHALL clear the stall within the same cycle (asynchronous).

Structure
REQ-031 ctrl_t, the ALU op constants and the opcode constants SHALL live in shared package rv_ctrl_pkg.
REQ-032 The combinational decoder SHALL be one sub-module, rv_decoder; this block adds only the registers, scoreboard, hazard, branch and counter logic.

Verification
REQ-033 add x1,x2,x3 then add x4,x1,x5 with SB_DEPTH=3 -> o_id_stall=1 for 3 cycles, 3 bubbles, then x4 enters EX; o_stall_cnt=3.
REQ-034 beq taken (i_br_equal=1) with a hazarding instruction in ID -> o_pc_sel=o_flush=1, o_id_stall=0, next o_ex_valid=0.
REQ-035 Writer with rd=x0 followed by a reader of x0 -> no stall.
REQ-036 Instruction 32'h02208033 (mul) -> with EN_MEXT=0: o_ex_illegal=1, rd_wren=0; with EN_MEXT=1: alu_op=11.
REQ-037 srai x1,x1,3 -> alu_op SRA; slli encoded with funct7=0100000 -> illegal.
REQ-038 CNT_W=2 with 5 stall cycles -> o_stall_cnt=3; i_reset pulsed low mid-stall -> all outputs 0 immediately.
